// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: FSM state encodings and default widths.
package mdu_pkg;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned CNT_W_DEF = 5;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: conditionally add the multiplicand into hi, then shift {hi,lo} right.
module mult_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   hi,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] mcand,
   output logic [WIDTH:0]   hi_next,
   output logic [WIDTH-1:0] lo_next
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum = lo[0] ? (hi + {1'b0, mcand}) : hi;
      {hi_next, lo_next} = {1'b0, sum, lo[WIDTH-1:1]};
   end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier for MULT/MULTU; fixed WIDTH+1 cycle latency, result
// strobed straight into the HI/LO register.
module seq_multiplier
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic               Start,
   input  logic               Signed,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               Busy,
   output logic               Done,
   output logic               HiLo_En,
   output logic [2*WIDTH-1:0] Product
);

   logic [1:0]         state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH:0]     hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic [WIDTH-1:0]   mcand_q;
   logic               neg_q;
   logic [2*WIDTH-1:0] product_q;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               neg_d;
   logic [WIDTH:0]     hi_next;
   logic [WIDTH-1:0]   lo_next;
   logic [2*WIDTH-1:0] acc_next, prod_next;
   logic               last;

   // The magnitude of the most negative value wraps back to itself, read as unsigned.
   always_comb begin
      a_mag     = (Signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
      b_mag     = (Signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
      neg_d     = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
      acc_next  = {hi_next[WIDTH-1:0], lo_next};
      prod_next = neg_q ? (~acc_next + 1'b1) : acc_next;
      last      = (cnt_q == CNT_W'(WIDTH - 1));
   end

   mult_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .hi      (hi_q),
      .lo      (lo_q),
      .mcand   (mcand_q),
      .hi_next (hi_next),
      .lo_next (lo_next)
   );

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         mcand_q   <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (Start) begin
                  state_q <= RUN;
                  cnt_q   <= '0;
                  hi_q    <= '0;
                  lo_q    <= b_mag;
                  mcand_q <= a_mag;
                  neg_q   <= neg_d;
               end
            end
            RUN: begin
               hi_q  <= hi_next;
               lo_q  <= lo_next;
               cnt_q <= cnt_q + 1'b1;
               if (last) begin
                  state_q   <= DONE;
                  product_q <= prod_next;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Busy    = (state_q != IDLE);
   assign Done    = (state_q == DONE);
   assign HiLo_En = (state_q == DONE);
   assign Product = product_q;

endmodule
